// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: round-robin two-way mux select controller with minimum grant dwell and glitch-free X-free select
module mux_sel_ctrl #(
  parameter int DWELL = 4,
  parameter int CW = $clog2(DWELL + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_lock,
  output logic o_sel,
  output logic o_gnt_a,
  output logic o_gnt_b,
  output logic o_switch,
  output logic o_busy
);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d, switch_q, switch_d, busy_q, busy_d;
  logic expired, go_a, go_b, go_idle;
  if (DWELL < 1) begin : g_chk
    $error("mux_sel_ctrl: DWELL must be >= 1");
  end
  always_comb begin
    expired = cnt_q == CW'(DWELL);
    go_a = state_q == IDLE ? i_req_a && !(i_req_b && last_q) : state_q == GNT_B && expired && !i_lock && i_req_a;
    go_b = state_q == IDLE ? i_req_b && !(i_req_a && !last_q) : state_q == GNT_A && expired && !i_lock && i_req_b;
    go_idle = state_q != IDLE && expired && !i_lock && !i_req_a && !i_req_b;
    state_d = go_a ? GNT_A : go_b ? GNT_B : go_idle ? IDLE : state_q;
    cnt_d = go_a || go_b ? CW'(1) : state_q != IDLE && !expired ? cnt_q + CW'(1) : cnt_q;
    last_d = go_a ? 1'b1 : go_b ? 1'b0 : last_q;
    gnt_a_d = state_d == GNT_A;
    gnt_b_d = state_d == GNT_B;
    busy_d = state_d != IDLE;
    switch_d = state_q != IDLE && (go_a || go_b);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      switch_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      switch_q <= switch_d;
      busy_q <= busy_d;
    end
  end
  assign o_sel = last_q;
  assign o_gnt_a = gnt_a_q;
  assign o_gnt_b = gnt_b_q;
  assign o_switch = switch_q;
  assign o_busy = busy_q;
  always_comb begin
    if (!i_rst) begin
      assert final ((^o_sel) !== 1'bx) else $error("o_sel is X");
      assert final (!(o_gnt_a && o_gnt_b)) else $error("both grants high");
      assert final (!o_busy || (o_sel == o_gnt_a)) else $error("o_sel disagrees with grant");
      assert final (cnt_q <= CW'(DWELL)) else $error("cnt exceeds DWELL");
    end
  end
endmodule

// File: doc/mux_sel_ctrl.md
# mux_sel_ctrl

- Registered two-way select controller that drives the select line `z` of the downstream `I` interface.
- That select line steers the source-A/source-B output multiplexer: `z`=1 passes source A, `z`=0 passes source B.
- Arbitrates two requesters round-robin and enforces a minimum grant dwell time.
- Guarantees the select is never X after reset, so the mux's X-check on `z` cannot fire.

## Interface
Parameters:
- `DWELL`, default 4: minimum number of cycles a grant is held. Legal range is ≥1; an elaboration-time check fails otherwise.
- `CW`, default `$clog2(DWELL+1)`: dwell counter width. Derived; do not override.

Ports:
- `i_clk` input 1: the single clock. All state changes on its rising edge.
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_req_a` input 1: source A requests the mux path.
- `i_req_b` input 1: source B requests the mux path.
- `i_lock` input 1: holds the current grant regardless of requests, once dwell has expired.
- `o_sel` output 1: select to the mux. Connected to `z`. 1 = A, 0 = B.
- `o_gnt_a` output 1: A currently owns the path.
- `o_gnt_b` output 1: B currently owns the path.
- `o_switch` output 1: one-cycle pulse in the first cycle after ownership moves directly A↔B.
- `o_busy` output 1: high when either grant is high.

## Operation
- States: IDLE, GNT_A, GNT_B.
- Also kept:
  - `last` (1 bit), the last served requester;
  - `cnt` (CW bits), the number of cycles the current grant has been held.
- Reset values (asynchronous): state IDLE, `o_sel`=0, `o_gnt_a`=0, `o_gnt_b`=0, `o_switch`=0, `o_busy`=0, `cnt`=0, `last`=B.
  - With `last`=B, A wins the first tie after reset.
- From IDLE:
  - only `i_req_a` → GNT_A;
  - only `i_req_b` → GNT_B;
  - both requests → the requester that is not `last`;
  - neither → stay in IDLE.
- On entering any grant:
  - `cnt`←1;
  - `o_sel` ← 1 for A, 0 for B;
  - `last` ← the granted requester.
- In GNT_X: `cnt` increments each cycle and saturates at DWELL. No exit is allowed while `cnt` < DWELL, even if `i_req_X` drops.
- In GNT_X with `cnt`==DWELL and `i_lock`=0:
  - other requester high → GNT_other, `cnt`←1, `o_switch`=1 for one cycle. This holds even if `i_req_X` is still high (fairness).
  - else if `i_req_X` low → IDLE.
  - else stay in GNT_X.
- In GNT_X with `cnt`==DWELL and `i_lock`=1: stay in GNT_X, `cnt` holds at DWELL.
- In IDLE, `o_sel` holds its last value. The mux path does not glitch on release.
- DWELL=1: a grant may move every cycle. Two requesters held high alternate A,B,A,B… with `o_switch` high on every cycle after the first grant.
- Embedded immediate assertions (`assert final`, `$error` on fail), active when `i_rst`=0:
  - `^o_sel !== 'x`;
  - `!(o_gnt_a && o_gnt_b)`;
  - if `o_busy` then `o_sel == o_gnt_a`;
  - `cnt <= DWELL`.

## Timing
- Every output is a flop output. Nothing is combinational from the inputs.
- Request to grant: 1 cycle. `i_req_a` sampled high at edge N gives `o_gnt_a`=1 and `o_sel`=1 after edge N.
- Minimum grant length: exactly DWELL cycles.
- Release to IDLE: the grant drops on the edge where `cnt`==DWELL and the request is low.
- `o_sel` changes only on the same edge as a grant change, never in between.
- `o_switch` is high for exactly one cycle, the cycle after the direct handover edge. It is never asserted on IDLE transitions.
- `i_lock` is sampled only when `cnt`==DWELL. Its value while `cnt`<DWELL has no effect.
- `i_rst` asserted mid-grant forces all outputs to their reset values immediately, without waiting for a clock.
  - After deassertion, the next grant starts with `cnt`=1 and `last`=B.

## Test plan
- Reset then tie: DWELL=4; `i_req_a`=`i_req_b`=1 from cycle 0.
  - Expect GNT_A for cycles 1–4, GNT_B for 5–8, then A again.
  - `o_switch`=1 at cycles 5 and 9; `o_sel` sequence 1,1,1,1,0,0,0,0,1.
- Early drop: DWELL=4; `i_req_b` pulses high for 1 cycle only.
  - Expect `o_gnt_b` high for exactly 4 cycles, then IDLE.
  - `o_sel` stays 0 afterwards; `o_switch` never fires.
- Lock: in GNT_A with `i_lock`=1 and `i_req_b`=1 for 10 cycles.
  - Expect A held for all 10 cycles.
  - After `i_lock` drops, B granted 1 cycle later with `o_switch`=1.
- DWELL=1 alternation: both requests high for 6 cycles.
  - Expect `o_sel` = 1,0,1,0,1,0 and `o_switch` high from cycle 2 on.
- Async reset mid-grant: assert `i_rst` between edges in GNT_B at `cnt`=2.
  - Expect all outputs 0 before the next edge.
  - After release with only `i_req_b`, expect a GNT_B lasting a full 4 cycles.
- X-freedom: random requests and lock for 10k cycles, with `i_rst` toggled 5 times.
  - Expect no firing of any embedded assertion, and `o_sel` never X/Z after the first reset.
